// File: rtl/text_console_pkg.sv
// Shared constants, state encoding and helpers for the VGA text console datapath.
package text_console_pkg;

    localparam int unsigned DEF_COLS = 32;
    localparam int unsigned DEF_ROWS = 4;

    localparam logic [7:0] CR       = 8'h0D;
    localparam logic [7:0] LF       = 8'h0A;
    localparam logic [7:0] BS       = 8'h08;
    localparam logic [7:0] FF       = 8'h0C;
    localparam logic [7:0] BLANK    = 8'h20;
    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    typedef enum logic [1:0] {
        StIdle,
        StFclr,
        StLclr
    } state_e;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= PRINT_LO) && (b <= PRINT_HI);
    endfunction

endpackage

// File: rtl/byte_skid_buf.sv
// One-entry pending byte register in front of the cursor writer, with a sticky drop flag.
module byte_skid_buf
    import text_console_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_idle,
    input  logic       i_rx_valid,
    input  logic [7:0] i_rx_data,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_overflow
);

    logic       r_full;
    logic [7:0] r_data;
    logic       r_overflow;

    logic w_pop;
    logic w_bypass;
    logic w_slot_free;

    // A held byte always wins; a new byte then refills the slot just freed.
    assign w_pop       = i_idle && r_full;
    assign w_bypass    = i_idle && !r_full;
    assign w_slot_free = !r_full || w_pop;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_full     <= 1'b0;
            r_data     <= 8'h00;
            r_overflow <= 1'b0;
        end else if (i_rx_valid && !w_bypass) begin
            if (w_slot_free) begin
                r_full <= 1'b1;
                r_data <= i_rx_data;
            end else begin
                r_overflow <= 1'b1;
            end
        end else if (w_pop) begin
            r_full <= 1'b0;
        end
    end

    assign o_valid    = i_idle && (r_full || i_rx_valid);
    assign o_data     = r_full ? r_data : i_rx_data;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/text_cursor_writer.sv
// Turns received bytes into character RAM writes, tracking the cursor and blanking
// the screen or the newly entered line so stale text never shows.
module text_cursor_writer
    import text_console_pkg::*;
#(
    parameter int unsigned COLS       = DEF_COLS,
    parameter int unsigned ROWS       = DEF_ROWS,
    parameter int unsigned COL_W      = 5,
    parameter int unsigned ROW_W      = 2,
    parameter logic [7:0]  BLANK_CHAR = BLANK
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    output logic             o_wr_en,
    output logic [ROW_W-1:0] o_wr_row,
    output logic [COL_W-1:0] o_wr_col,
    output logic [7:0]       o_wr_data,
    output logic [ROW_W-1:0] o_cur_row,
    output logic [COL_W-1:0] o_cur_col,
    output logic             o_busy,
    output logic             o_overflow
);

    localparam int unsigned     IDX_W   = COL_W + ROW_W + 1;
    localparam int unsigned     CELLS   = COLS * ROWS;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);

    state_e             r_state, w_state_d;
    logic [IDX_W-1:0]   r_idx, w_idx_d;
    logic [ROW_W-1:0]   r_row, w_row_d;
    logic [COL_W-1:0]   r_col, w_col_d;
    logic               r_last_cr, w_last_cr_d;
    logic               r_wr_en, w_wr_en_d;
    logic [ROW_W-1:0]   r_wr_row, w_wr_row_d;
    logic [COL_W-1:0]   r_wr_col, w_wr_col_d;
    logic [7:0]         r_wr_data, w_wr_data_d;
    logic               r_busy;

    logic       w_byte_valid;
    logic [7:0] w_byte;

    byte_skid_buf u_skid (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_idle     (r_state == StIdle),
        .i_rx_valid (i_rx_valid),
        .i_rx_data  (i_rx_data),
        .o_valid    (w_byte_valid),
        .o_data     (w_byte),
        .o_overflow (o_overflow)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= StFclr;
            r_idx     <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_last_cr <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_row  <= '0;
            r_wr_col  <= '0;
            r_wr_data <= 8'h00;
            r_busy    <= 1'b1;
        end else begin
            r_state   <= w_state_d;
            r_idx     <= w_idx_d;
            r_row     <= w_row_d;
            r_col     <= w_col_d;
            r_last_cr <= w_last_cr_d;
            r_wr_en   <= w_wr_en_d;
            r_wr_row  <= w_wr_row_d;
            r_wr_col  <= w_wr_col_d;
            r_wr_data <= w_wr_data_d;
            r_busy    <= (w_state_d != StIdle);
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_idx_d     = r_idx;
        w_row_d     = r_row;
        w_col_d     = r_col;
        w_last_cr_d = r_last_cr;
        w_wr_en_d   = 1'b0;
        w_wr_row_d  = r_wr_row;
        w_wr_col_d  = r_wr_col;
        w_wr_data_d = r_wr_data;
        unique case (r_state)
            StIdle: begin
                if (w_byte_valid) begin
                    w_last_cr_d = (w_byte == CR);
                    if (is_printable(w_byte)) begin
                        w_wr_en_d   = 1'b1;
                        w_wr_row_d  = r_row;
                        w_wr_col_d  = r_col;
                        w_wr_data_d = w_byte;
                        if (r_col == COL_MAX) begin
                            w_col_d   = '0;
                            w_row_d   = r_row + ROW_W'(1);
                            w_state_d = StLclr;
                            w_idx_d   = '0;
                        end else begin
                            w_col_d = r_col + COL_W'(1);
                        end
                    // LF straight after CR is swallowed so CRLF moves one line.
                    end else if ((w_byte == CR) || ((w_byte == LF) && !r_last_cr)) begin
                        w_col_d   = '0;
                        w_row_d   = r_row + ROW_W'(1);
                        w_state_d = StLclr;
                        w_idx_d   = '0;
                    end else if (w_byte == BS) begin
                        if (r_col != '0) begin
                            w_col_d     = r_col - COL_W'(1);
                            w_wr_en_d   = 1'b1;
                            w_wr_row_d  = r_row;
                            w_wr_col_d  = r_col - COL_W'(1);
                            w_wr_data_d = BLANK_CHAR;
                        end
                    end else if (w_byte == FF) begin
                        w_row_d   = '0;
                        w_col_d   = '0;
                        w_state_d = StFclr;
                        w_idx_d   = '0;
                    end
                end
            end
            StFclr: begin
                if (r_idx == IDX_W'(CELLS)) begin
                    w_state_d = StIdle;
                end else begin
                    w_wr_en_d   = 1'b1;
                    w_wr_row_d  = r_idx[COL_W +: ROW_W];
                    w_wr_col_d  = r_idx[COL_W-1:0];
                    w_wr_data_d = BLANK_CHAR;
                    w_idx_d     = r_idx + IDX_W'(1);
                end
            end
            StLclr: begin
                if (r_idx == IDX_W'(COLS)) begin
                    w_state_d = StIdle;
                end else begin
                    w_wr_en_d   = 1'b1;
                    w_wr_row_d  = r_row;
                    w_wr_col_d  = r_idx[COL_W-1:0];
                    w_wr_data_d = BLANK_CHAR;
                    w_idx_d     = r_idx + IDX_W'(1);
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign o_wr_en   = r_wr_en;
    assign o_wr_row  = r_wr_row;
    assign o_wr_col  = r_wr_col;
    assign o_wr_data = r_wr_data;
    assign o_cur_row = r_row;
    assign o_cur_col = r_col;
    assign o_busy    = r_busy;

endmodule

// File: tb/tb_text_cursor_writer.sv
// Directed bench for text_cursor_writer: per-cycle comparison against a sweep-queue model
// plus literal expectations for the main scenarios.
module tb_text_cursor_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       wr_en;
    logic [1:0] wr_row;
    logic [4:0] wr_col;
    logic [7:0] wr_data;
    logic [1:0] cur_row;
    logic [4:0] cur_col;
    logic       busy;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;

    text_cursor_writer dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid),
        .o_wr_en    (wr_en),
        .o_wr_row   (wr_row),
        .o_wr_col   (wr_col),
        .o_wr_data  (wr_data),
        .o_cur_row  (cur_row),
        .o_cur_col  (cur_col),
        .o_busy     (busy),
        .o_overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a sweep is a list of cells followed by one idle marker; busy while any remain.
    typedef struct packed {
        logic       en;
        logic [1:0] row;
        logic [4:0] col;
        logic [7:0] data;
    } cell_t;

    cell_t      m_sweep[$];
    bit         m_valid = 0;
    bit         m_pv, m_ovf, m_lastcr;
    logic [7:0] m_pd;
    int         m_row, m_col;
    logic       e_wr_en, e_busy;
    logic [1:0] e_row;
    logic [4:0] e_col;
    logic [7:0] e_data;

    task automatic m_write(input int r, input int c, input logic [7:0] d);
        e_wr_en = 1'b1;
        e_row   = 2'(r);
        e_col   = 5'(c);
        e_data  = d;
    endtask

    task automatic m_push_line(input int r);
        for (int c = 0; c < 32; c++) m_sweep.push_back(cell_t'{1'b1, 2'(r), 5'(c), 8'h20});
        m_sweep.push_back(cell_t'{1'b0, 2'd0, 5'd0, 8'h00});
    endtask

    task automatic m_push_screen();
        for (int k = 0; k < 128; k++) m_sweep.push_back(cell_t'{1'b1, 2'(k / 32), 5'(k % 32), 8'h20});
        m_sweep.push_back(cell_t'{1'b0, 2'd0, 5'd0, 8'h00});
    endtask

    task automatic m_new_line();
        m_col = 0;
        m_row = (m_row + 1) % 4;
        m_push_line(m_row);
    endtask

    task automatic m_process(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            m_write(m_row, m_col, b);
            m_lastcr = 0;
            if (m_col == 31) m_new_line();
            else m_col++;
        end else if (b == 8'h0D) begin
            m_new_line();
            m_lastcr = 1;
        end else if (b == 8'h0A) begin
            if (!m_lastcr) m_new_line();
            m_lastcr = 0;
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                m_write(m_row, m_col, 8'h20);
            end
            m_lastcr = 0;
        end else if (b == 8'h0C) begin
            m_row = 0;
            m_col = 0;
            m_push_screen();
            m_lastcr = 0;
        end else begin
            m_lastcr = 0;
        end
    endtask

    always @(posedge clk) begin
        bit         idle, have, to_pend;
        logic [7:0] cmd;
        cell_t      c;
        if (reset) begin
            m_sweep.delete();
            m_push_screen();
            m_row = 0; m_col = 0; m_lastcr = 0; m_pv = 0; m_ovf = 0;
            e_wr_en = 1'b0; e_busy = 1'b1;
            m_valid = 1;
        end else if (m_valid) begin
            idle    = (m_sweep.size() == 0);
            have    = 0;
            cmd     = 8'h00;
            to_pend = rx_valid;
            e_wr_en = 1'b0;
            if (idle) begin
                if (m_pv) begin
                    cmd = m_pd; have = 1; m_pv = 0;
                end else if (rx_valid) begin
                    cmd = rx_data; have = 1; to_pend = 0;
                end
            end
            if (to_pend) begin
                if (!m_pv) begin
                    m_pv = 1; m_pd = rx_data;
                end else begin
                    m_ovf = 1;
                end
            end
            if (!idle) begin
                c = m_sweep.pop_front();
                if (c.en) m_write(c.row, c.col, c.data);
            end else if (have) begin
                m_process(cmd);
            end
            e_busy = (m_sweep.size() != 0);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("wr_en", wr_en, e_wr_en);
            if (e_wr_en) chk("wr_cell", {wr_row, wr_col, wr_data}, {e_row, e_col, e_data});
            chk("busy", busy, e_busy);
            chk("cur_row", cur_row, m_row);
            chk("cur_col", cur_col, m_col);
            chk("overflow", overflow, m_ovf);
        end
    end

    // Write log, sampled just after the active edge.
    typedef struct packed {
        logic [1:0] row;
        logic [4:0] col;
        logic [7:0] data;
    } wr_t;
    wr_t log_q[$];

    always @(posedge clk) begin
        #1;
        if (wr_en) log_q.push_back(wr_t'{wr_row, wr_col, wr_data});
    end

    function automatic int sweep_errs(input int start, input int n, input int fixed_row);
        int errs = 0;
        wr_t exp_w;
        for (int k = 0; k < n; k++) begin
            exp_w = wr_t'{2'((fixed_row >= 0) ? fixed_row : k / 32), 5'(k % 32), 8'h20};
            if (log_q.size() <= start + k) errs++;
            else if (log_q[start + k] != exp_w) errs++;
        end
        return errs;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (!busy) return;
            @(negedge clk);
        end
        chk("wait_idle_timeout", busy, 0);
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        log_q.delete();
        chk("busy_after_reset", busy, 1);
        wait_idle();
        chk("init_write_count", log_q.size(), 128);
        chk("init_sweep_cells", sweep_errs(0, 128, -1), 0);
        chk("init_cursor", {cur_row, cur_col}, 0);

        send_byte(8'h41);
        chk("A_wr_en", wr_en, 1);
        chk("A_cell", {wr_row, wr_col, wr_data}, {2'd0, 5'd0, 8'h41});
        chk("A_cur_col", cur_col, 1);

        send_byte(8'h0C);
        wait_idle();
        for (int i = 0; i < 32; i++) send_byte(8'h61 + 8'(i % 26));
        chk("wrap_cell", {wr_row, wr_col, wr_data}, {2'd0, 5'd31, 8'h66});
        chk("wrap_cursor", {cur_row, cur_col}, {2'd1, 5'd0});
        chk("wrap_busy", busy, 1);
        log_q.delete();
        send_byte(8'h5A);
        wait_idle();
        @(negedge clk);
        chk("row1_write_count", log_q.size(), 33);
        chk("row1_sweep_cells", sweep_errs(0, 32, 1), 0);
        if (log_q.size() == 33) chk("held_byte_cell", log_q[32], {2'd1, 5'd0, 8'h5A});
        chk("held_byte_cursor", {cur_row, cur_col}, {2'd1, 5'd1});

        send_byte(8'h0A);
        wait_idle();
        send_byte(8'h0A);
        wait_idle();
        chk("row3_cursor", {cur_row, cur_col}, {2'd3, 5'd0});
        log_q.delete();
        send_byte(8'h0D);
        wait_idle();
        send_byte(8'h0A);
        @(negedge clk);
        chk("crlf_cursor", {cur_row, cur_col}, 0);
        chk("crlf_busy", busy, 0);
        chk("crlf_write_count", log_q.size(), 32);
        chk("crlf_sweep_cells", sweep_errs(0, 32, 0), 0);
        send_byte(8'h0A);
        chk("lf_cursor", {cur_row, cur_col}, {2'd1, 5'd0});
        wait_idle();

        send_byte(8'h0A);
        wait_idle();
        for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i));
        send_byte(8'h58);
        send_byte(8'h59);
        send_byte(8'h08);
        chk("bs_wr_en", wr_en, 1);
        chk("bs_cell", {wr_row, wr_col, wr_data}, {2'd2, 5'd6, 8'h20});
        chk("bs_cursor", {cur_row, cur_col}, {2'd2, 5'd6});
        send_byte(8'h0D);
        wait_idle();
        log_q.delete();
        send_byte(8'h08);
        repeat (2) @(negedge clk);
        chk("bs_col0_writes", log_q.size(), 0);
        chk("bs_col0_cursor", {cur_row, cur_col}, {2'd3, 5'd0});

        log_q.delete();
        send_byte(8'h0C);
        send_byte(8'h50);
        send_byte(8'h51);
        send_byte(8'h52);
        chk("ff_overflow", overflow, 1);
        wait_idle();
        @(negedge clk);
        chk("ff_write_count", log_q.size(), 129);
        chk("ff_sweep_cells", sweep_errs(0, 128, -1), 0);
        if (log_q.size() == 129) chk("ff_held_cell", log_q[128], {2'd0, 5'd0, 8'h50});
        chk("ff_cursor", {cur_row, cur_col}, {2'd0, 5'd1});
        chk("overflow_sticky", overflow, 1);

        send_byte(8'h0C);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_overflow", overflow, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_busy", busy, 1);
        log_q.delete();
        wait_idle();
        chk("rst_sweep_cells", sweep_errs(0, 128, -1), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/text_cursor_writer.md
Name: text_cursor_writer

Overview:
- Sits between the UART receiver and the dual-port character RAM of the VGA text console.
- Consumes received bytes and interprets control codes.
- Maintains the cursor and issues single-cell writes on the RAM write port.
- Runs blanking sweeps for reset, new lines and form feed, so the display never shows stale text.

Parameters:
COLS, 32, characters per row (power of two)
ROWS, 4, text rows (power of two)
COL_W, 5, log2(COLS)
ROW_W, 2, log2(ROWS)
BLANK, 8'h20, fill character for cleared cells

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  synchronous, active-high; clears all state and starts a full-screen blank
rx_data  in  8  received byte; valid only while rx_valid=1
rx_valid  in  1  single-cycle strobe, byte present
wr_en  out  1  RAM write strobe, one cycle per cell
wr_row  out  ROW_W  RAM write row
wr_col  out  COL_W  RAM write column
wr_data  out  8  RAM write data
cur_row  out  ROW_W  current cursor row (for 7-seg and debug)
cur_col  out  COL_W  current cursor column
busy  out  1  high whenever state is not IDLE
overflow  out  1  sticky; a byte was dropped

Behaviour:
- Interface: one clock domain; `reset` is synchronous and active-high. All outputs are registered.
- Reset cycle values:
  - wr_en=0, cursor=(0,0), overflow=0, pending empty, last_cr=0.
  - State goes to FCLR with sweep index 0. busy=1 from the first cycle after reset.
- States:
  - IDLE: waiting for a byte.
  - FCLR: full-screen sweep. Writes BLANK to index 0..COLS*ROWS-1, one cell per cycle, row-major (row=idx[hi], col=idx[lo]). After the last cell → IDLE.
  - LCLR: line sweep. Writes BLANK to cols 0..COLS-1 of cur_row, one per cycle, then → IDLE.
- Byte source: IDLE takes the pending byte if one is held, otherwise rx_valid/rx_data. Accept at edge N; effects are visible at cycle N+1.
- Printable byte (0x20–0x7E):
  - Cycle N+1: wr_en=1 at the old cursor with wr_data=byte; the cursor advances in the same cycle.
  - Advance: col+1. At col=COLS-1 the column goes to 0 and the row goes to row+1, wrapping ROWS-1→0 (no scrolling), then state → LCLR for the new row.
  - The LCLR sweep starts the cycle after the character write.
- CR (0x0D) or LF (0x0A): col←0, row←row+1 (wrapped), → LCLR. No character write.
  - An LF accepted when last_cr=1 is a no-op, so CRLF advances only one line.
  - last_cr is set by CR and cleared by any other accepted byte.
- BS (0x08):
  - If col>0: col←col−1 and write BLANK at the new position.
  - If col=0: no write, no move.
- FF (0x0C): cursor←(0,0), → FCLR.
- All other bytes (other control codes, 0x7F–0xFF): ignored, no write, last_cr cleared.
- One-entry pending register: rx_valid is always sampled.
  - If busy, or in IDLE while pending is already being consumed: the byte goes into pending if it is empty.
  - If pending is full: the byte is dropped and overflow←1. overflow clears only on reset.
  - IDLE consumes pending before any new rx byte. A new rx byte in the same cycle goes into the just-freed pending slot.
- During a sweep the cursor does not move. cur_row/cur_col always show the post-command cursor.
- reset mid-sweep or mid-write: the sweep aborts, state is re-initialised, and FCLR restarts from index 0.
- wr_en is never high for two different sources in the same cycle. Maximum write rate is one cell per cycle.

Decomposition:
- Shared package `text_console_pkg`:
  - ASCII constants: CR, LF, BS, FF, BLANK, PRINT_LO, PRINT_HI.
  - State encoding IDLE/FCLR/LCLR.
  - COLS/ROWS defaults.
- One natural sub-module: `byte_skid_buf`, the one-entry pending register with the overflow flag.

Test Plan:
- Reset pulse → exactly 128 consecutive wr_en cycles with wr_data=8'h20, row-major (0,0)…(3,31). busy falls the cycle after the last write. Cursor reads (0,0).
- After the clear, send 'A' (8'h41) → next cycle wr_en=1, (0,0), 8'h41. cur_col=1.
- 32 printable bytes from (0,0):
  - Expect a write at (0,31), then cursor=(1,0) with busy=1.
  - Expect 32 BLANK writes on row 1.
  - A 33rd byte sent during the sweep is written at (1,0) after the sweep.
- Cursor at row 3: send CR then LF → a single line advance to (0,0) and one LCLR of row 0. A second, standalone LF moves to (1,0).
- Bytes 'X','Y' at (2,5) then BS → write 8'h20 at (2,6), cursor (2,6). A BS at col 0 → no wr_en.
- During an FF sweep, send 3 bytes → the first is held and processed after the sweep, the second and third are dropped, and overflow=1 until the next reset.
